// File: rtl/triangle_seq_checker_pkg.sv
// Shared encodings for the triangle count-stream checker.
package triangle_seq_checker_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HUNT  = 2'd1,
        ST_UP    = 2'd2,
        ST_DOWN  = 2'd3
    } state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/triangle_seq_checker_sat_counter.sv
// Event counter with sync clear; saturates at all-ones or wraps.
module triangle_seq_checker_sat_counter #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             full;

    assign full = SATURATE && (&count_q);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && !full) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/triangle_seq_checker.sv
// Locks onto a 0..MAX..0 ping-pong count stream and flags deviations.
module triangle_seq_checker #(
    parameter int WIDTH      = 3,
    parameter int LOCK_COUNT = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] inNum,
    output logic             locked,
    output logic             direction,
    output logic             errPulse,
    output logic             periodPulse,
    output logic [7:0]       errCount,
    output logic [15:0]      periodCount
);
    import triangle_seq_checker_pkg::*;

    localparam logic [WIDTH-1:0] MAX    = {WIDTH{1'b1}};
    localparam int               GW     = $clog2(LOCK_COUNT + 1);
    localparam logic [GW-1:0]    LOCK_N = GW'(LOCK_COUNT);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [GW-1:0]    good_q, good_d, good_inc;
    logic             locked_q, locked_d;
    logic             dir_q, dir_d;
    logic             err_q, err_d;
    logic             per_q, per_d;
    logic             up_step, down_step;

    // Widened compares so MAX->0 and 0->MAX never count as a step.
    assign up_step   = {1'b0, inNum}  == {1'b0, prev_q} + (WIDTH+1)'(1);
    assign down_step = {1'b0, prev_q} == {1'b0, inNum}  + (WIDTH+1)'(1);
    assign good_inc  = (good_q >= LOCK_N) ? good_q : good_q + GW'(1);

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        good_d  = good_q;
        err_d   = 1'b0;
        per_d   = 1'b0;
        if (enable) begin
            prev_d = inNum;
            unique case (state_q)
                ST_EMPTY: begin
                    state_d = ST_HUNT;
                end
                ST_HUNT: begin
                    if (up_step) begin
                        state_d = (inNum == MAX) ? ST_DOWN : ST_UP;
                        good_d  = GW'(1);
                    end else if (down_step) begin
                        state_d = (inNum == '0) ? ST_UP : ST_DOWN;
                        good_d  = GW'(1);
                    end
                end
                ST_UP: begin
                    if (up_step) begin
                        good_d = good_inc;
                        if (inNum == MAX) state_d = ST_DOWN;
                    end else begin
                        err_d   = 1'b1;
                        good_d  = '0;
                        state_d = ST_HUNT;
                    end
                end
                ST_DOWN: begin
                    if (down_step) begin
                        good_d = good_inc;
                        if (inNum == '0) begin
                            state_d = ST_UP;
                            per_d   = 1'b1;
                        end
                    end else begin
                        err_d   = 1'b1;
                        good_d  = '0;
                        state_d = ST_HUNT;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        locked_d = (good_d >= LOCK_N) &&
                   (state_d == ST_UP || state_d == ST_DOWN);
        dir_d    = (state_d == ST_DOWN) ? DIR_DOWN : DIR_UP;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_EMPTY;
            prev_q   <= '0;
            good_q   <= '0;
            locked_q <= 1'b0;
            dir_q    <= DIR_UP;
            err_q    <= 1'b0;
            per_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            good_q   <= good_d;
            locked_q <= locked_d;
            dir_q    <= dir_d;
            err_q    <= err_d;
            per_q    <= per_d;
        end
    end

    assign locked      = locked_q;
    assign direction   = dir_q;
    assign errPulse    = err_q;
    assign periodPulse = per_q;

    triangle_seq_checker_sat_counter #(
        .WIDTH    (8),
        .SATURATE (1'b1)
    ) u_err_cnt (
        .clk_i   (clock),
        .rst_ni  (reset),
        .clear_i (clear),
        .inc_i   (err_d),
        .count_o (errCount)
    );

    triangle_seq_checker_sat_counter #(
        .WIDTH    (16),
        .SATURATE (1'b0)
    ) u_per_cnt (
        .clk_i   (clock),
        .rst_ni  (reset),
        .clear_i (clear),
        .inc_i   (per_d),
        .count_o (periodCount)
    );

endmodule
